// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys derived on the fly.
// Optional rk10 key cache enabled by defining AES_DEC_KEY_CACHE_EN.

package aes_decrypt_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a   [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = col[31-8*i -: 8];
      x2     = xtime(a[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[i] = x8 ^ a[i];
      m0b[i] = x8 ^ x2 ^ a[i];
      m0d[i] = x8 ^ x4 ^ a[i];
      m0e[i] = x8 ^ x4 ^ x2;
    end
    return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
            m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
            m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
            m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
  endfunction

endpackage

module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import aes_decrypt_pkg::*;
  logic [7:0] w_inv;
  assign w_inv = gf_inv(i_a);
  assign o_s   = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3) ^ rotl8(w_inv, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import aes_decrypt_pkg::*;
  logic [7:0] w_aff;
  assign w_aff = rotl8(i_a, 1) ^ rotl8(i_a, 3) ^ rotl8(i_a, 6) ^ 8'h05;
  assign o_s   = gf_inv(w_aff);
endmodule

module aes_decrypt_core (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);
  import aes_decrypt_pkg::*;

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_ADDK, S_DEC, S_DONE} fsm_t;

  fsm_t         r_fsm, w_fsm_nxt;
  logic [3:0]   r_rnd;
  logic [7:0]   r_rcon;
  logic [127:0] r_ct, r_key, r_st, r_data_out;
  logic         r_valid, r_busy;

  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_kp1, w_kp2, w_kp3;
  logic [31:0]  w_sub_in, w_sub_out;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3, w_kp0;
  logic [127:0] w_key_fwd, w_key_inv;
  logic [127:0] w_isr, w_isb, w_ark, w_imc, w_round;
  logic [7:0]   w_rcon_prev;
  logic         w_cache_hit;
  logic [127:0] w_rk10_cached;

  assign {w_k0, w_k1, w_k2, w_k3} = r_key;
  assign w_kp3 = w_k3 ^ w_k2;
  assign w_kp2 = w_k2 ^ w_k1;
  assign w_kp1 = w_k1 ^ w_k0;

  // One SubWord unit serves both directions: RotWord(k3) forwards, RotWord(kp3) backwards
  assign w_sub_in = (r_fsm == S_DEC) ? {w_kp3[23:0], w_kp3[31:24]} : {w_k3[23:0], w_k3[31:24]};

  genvar gi, gc, gr;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key_sbox
      aes_sbox u_sbox (.i_a(w_sub_in[31-8*gi -: 8]), .o_s(w_sub_out[31-8*gi -: 8]));
    end
  endgenerate

  assign w_f0      = w_k0 ^ w_sub_out ^ {r_rcon, 24'h000000};
  assign w_f1      = w_k1 ^ w_f0;
  assign w_f2      = w_k2 ^ w_f1;
  assign w_f3      = w_k3 ^ w_f2;
  assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};
  assign w_kp0     = w_k0 ^ w_sub_out ^ {r_rcon, 24'h000000};
  assign w_key_inv = {w_kp0, w_kp1, w_kp2, w_kp3};

  assign w_rcon_prev = (r_rcon == 8'h1b) ? 8'h80 : {1'b0, r_rcon[7:1]};

  // Byte b = 4*col + row; InvShiftRows rotates row r right by r columns
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        localparam int DST = 4 * gc + gr;
        localparam int SRC = 4 * ((gc - gr + 4) % 4) + gr;
        assign w_isr[127-8*DST -: 8] = r_st[127-8*SRC -: 8];
        aes_inv_sbox u_inv_sbox (.i_a(w_isr[127-8*DST -: 8]), .o_s(w_isb[127-8*DST -: 8]));
      end
      assign w_imc[127-32*gc -: 32] = inv_mix_col(w_ark[127-32*gc -: 32]);
    end
  endgenerate

  assign w_ark   = w_isb ^ w_key_inv;
  assign w_round = (r_rnd == 4'd0) ? w_ark : w_imc;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_last_key, r_rk10_cache;
  logic         r_cache_vld;

  assign w_cache_hit   = r_cache_vld && (AES_key_in == r_last_key);
  assign w_rk10_cached = r_rk10_cache;

  // Remember the most recent expanded key so a repeated key skips KEXP
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_last_key   <= 128'h0;
      r_rk10_cache <= 128'h0;
      r_cache_vld  <= 1'b0;
    end else if ((r_fsm == S_IDLE) && AES_en && !w_cache_hit) begin
      r_last_key  <= AES_key_in;
      r_cache_vld <= 1'b0;
    end else if ((r_fsm == S_KEXP) && (r_rnd == 4'd10)) begin
      r_rk10_cache <= w_key_fwd;
      r_cache_vld  <= 1'b1;
    end else begin
      r_cache_vld <= r_cache_vld;
    end
  end
`else
  assign w_cache_hit   = 1'b0;
  assign w_rk10_cached = 128'h0;
`endif

  // FSM next-state decode
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: begin
        if (AES_en) w_fsm_nxt = w_cache_hit ? S_ADDK : S_KEXP;
        else        w_fsm_nxt = S_IDLE;
      end
      S_KEXP: begin
        if (r_rnd == 4'd10) w_fsm_nxt = S_ADDK;
        else                w_fsm_nxt = S_KEXP;
      end
      S_ADDK: w_fsm_nxt = S_DEC;
      S_DEC: begin
        if (r_rnd == 4'd0) w_fsm_nxt = S_DONE;
        else               w_fsm_nxt = S_DEC;
      end
      S_DONE:  w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) r_fsm <= S_IDLE;
    else            r_fsm <= w_fsm_nxt;
  end

  // Datapath: key schedule, round state and output registers
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_rnd      <= 4'd0;
      r_rcon     <= 8'h01;
      r_ct       <= 128'h0;
      r_key      <= 128'h0;
      r_st       <= 128'h0;
      r_data_out <= 128'h0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_busy  <= (w_fsm_nxt != S_IDLE);
      case (r_fsm)
        S_IDLE: begin
          if (AES_en) begin
            r_ct   <= AES_data_in;
            r_key  <= w_cache_hit ? w_rk10_cached : AES_key_in;
            r_rnd  <= 4'd1;
            r_rcon <= 8'h01;
          end
        end
        S_KEXP: begin
          r_key <= w_key_fwd;
          if (r_rnd != 4'd10) begin
            r_rcon <= xtime(r_rcon);
            r_rnd  <= r_rnd + 4'd1;
          end
        end
        S_ADDK: begin
          r_st   <= r_ct ^ r_key;
          r_rnd  <= 4'd9;
          r_rcon <= 8'h36;
        end
        S_DEC: begin
          r_st   <= w_round;
          r_key  <= w_key_inv;
          r_rcon <= w_rcon_prev;
          r_rnd  <= r_rnd - 4'd1;
        end
        S_DONE: begin
          r_data_out <= r_st;
          r_valid    <= 1'b1;
        end
        default: r_rnd <= 4'd0;
      endcase
    end
  end

  assign AES_data_out       = r_data_out;
  assign AES_data_out_valid = r_valid;
  assign AES_busy           = r_busy;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed-vector bench for aes_decrypt_core (FIPS-197 / SP800-38A known answers).
// Latency expectations follow AES_DEC_KEY_CACHE_EN when the macro is defined.

module tb_aes_decrypt_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [127:0] din = 128'h0;
  logic [127:0] kin = 128'h0;
  logic [127:0] dout;
  logic         valid;
  logic         busy;

  aes_decrypt_core dut (
    .AES_clk(clk), .AES_rst_n(rst_n), .AES_en(en),
    .AES_data_in(din), .AES_key_in(kin),
    .AES_data_out(dout), .AES_data_out_valid(valid), .AES_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t         vecs [7];
  int           n_tests = 0;
  int           n_fail = 0;
  bit           m_vld = 1'b0;
  logic [127:0] m_key = 128'h0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    return (m_vld && (k == m_key)) ? 12 : 22;
`else
    return 22;
`endif
  endfunction

  task automatic model_start(input logic [127:0] k);
    m_key = k;
    m_vld = 1'b1;
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start one block, scramble inputs while busy, wait for valid (bounded)
  task automatic run_block(input logic [127:0] k, input logic [127:0] c,
                           output logic [127:0] pt, output int lat, output int bcnt,
                           output logic busy_at_valid, output logic valid_next);
    bit seen;
    @(negedge clk);
    kin = k;
    din = c;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    kin = ~k;
    din = ~c;
    lat = 0;
    bcnt = busy ? 1 : 0;
    pt = 128'h0;
    busy_at_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid) begin
        pt = dout;
        busy_at_valid = busy;
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
    end
    if (!seen) lat = -1;
    @(posedge clk);
    #1;
    valid_next = valid;
  endtask

  initial begin
    logic [127:0] pt, o1, o2;
    int           lat, bcnt, el, nv, v1, v2, vcnt;
    logic         bav, vnx;

    vecs[0] = '{C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{B_KEY, B_CT, B_PT};
    vecs[2] = '{B_KEY, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[3] = '{B_KEY, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[4] = '{B_KEY, 128'h43b1cd7f598ece23881b00e3ed030688, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    vecs[5] = '{B_KEY, 128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710};
    vecs[6] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    repeat (3) @(posedge clk);
    #1;
    chk128("reset data_out", dout, 128'h0);
    chk_int("reset valid", int'(valid), 0);
    chk_int("reset busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      el = exp_lat(vecs[v].key);
      model_start(vecs[v].key);
      run_block(vecs[v].key, vecs[v].ct, pt, lat, bcnt, bav, vnx);
      chk128($sformatf("vec%0d plaintext", v), pt, vecs[v].pt);
      chk_int($sformatf("vec%0d latency", v), lat, el);
      chk_int($sformatf("vec%0d busy cycles", v), bcnt, el);
      chk_int($sformatf("vec%0d busy at valid", v), int'(bav), 0);
      chk_int($sformatf("vec%0d valid width", v), int'(vnx), 0);
    end
    repeat (4) @(posedge clk);
    #1;
    chk128("data_out held", dout, vecs[6].pt);

    // Back-to-back: en stays high, inputs change while busy
    @(negedge clk);
    kin = C1_KEY;
    din = C1_CT;
    en  = 1'b1;
    nv = 0; v1 = -1; v2 = -1; o1 = 128'h0; o2 = 128'h0;
    el = exp_lat(C1_KEY);
    model_start(C1_KEY);
    for (int i = 0; i < 80 && nv < 2; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        kin = B_KEY;
        din = B_CT;
      end
      if (valid) begin
        if (nv == 0) begin
          v1 = i;
          o1 = dout;
        end else begin
          v2 = i;
          o2 = dout;
          en = 1'b0;
        end
        nv++;
      end
    end
    en = 1'b0;
    chk128("b2b first plaintext", o1, C1_PT);
    chk_int("b2b first latency", v1, el);
    el = exp_lat(B_KEY);
    model_start(B_KEY);
    chk128("b2b second plaintext", o2, B_PT);
    chk_int("b2b valid spacing", v2 - v1, el + 1);
    repeat (3) @(posedge clk);
    #1;
    chk_int("b2b idle after", int'(busy), 0);

    // Reset in the middle of a block
    @(negedge clk);
    kin = C1_KEY;
    din = C1_CT;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_vld = 1'b0;
    #1;
    chk128("abort data_out", dout, 128'h0);
    chk_int("abort valid", int'(valid), 0);
    chk_int("abort busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) vcnt++;
    end
    chk_int("abort no activity", vcnt, 0);

    for (int r = 0; r < 2; r++) begin
      el = exp_lat(C1_KEY);
      model_start(C1_KEY);
      run_block(C1_KEY, C1_CT, pt, lat, bcnt, bav, vnx);
      chk128($sformatf("post-reset run%0d plaintext", r), pt, C1_PT);
      chk_int($sformatf("post-reset run%0d latency", r), lat, el);
      chk_int($sformatf("post-reset run%0d valid width", r), int'(vnx), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
